// File: rtl/afu_port_flr_quiesce.sv
// Per-port FLR quiesce: stops AFU TX at a packet boundary, holds the AFU in reset, then acks.
// Optional statistics counters are enabled by defining FLR_QUIESCE_STATS_EN.
module afu_port_flr_quiesce #(
    parameter int unsigned TDATA_W         = 512,
    parameter int unsigned TUSER_W         = 10,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned DRAIN_TIMEOUT   = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flr_req,
    output logic               flr_done,
    output logic               afu_rst_n,
    output logic               drain_to_err,
    input  logic               s_tx_tvalid,
    output logic               s_tx_tready,
    input  logic               s_tx_tlast,
    input  logic [TDATA_W-1:0] s_tx_tdata,
    input  logic [TUSER_W-1:0] s_tx_tuser,
    output logic               m_tx_tvalid,
    input  logic               m_tx_tready,
    output logic               m_tx_tlast,
    output logic [TDATA_W-1:0] m_tx_tdata,
    output logic [TUSER_W-1:0] m_tx_tuser
`ifdef FLR_QUIESCE_STATS_EN
    ,
    output logic [15:0]        stat_flr_cnt,
    output logic [15:0]        stat_to_cnt
`endif
);

    localparam int unsigned HOLD_W  = $clog2(RST_HOLD_CYCLES + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state;
    logic                in_pkt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic gate_open;
    logic beat_acc;
    logic drain_exit;
    logic drain_to;
    logic hold_end;

    // Zero-latency TX gate; forced shut while rst is asserted.
    assign gate_open   = !rst && ((state == S_IDLE) || ((state == S_DRAIN) && in_pkt));
    assign m_tx_tvalid = s_tx_tvalid && gate_open;
    assign s_tx_tready = rst ? 1'b0 : (gate_open ? m_tx_tready : (state == S_HOLD));
    assign m_tx_tlast  = s_tx_tlast;
    assign m_tx_tdata  = s_tx_tdata;
    assign m_tx_tuser  = s_tx_tuser;

    assign beat_acc   = m_tx_tvalid && m_tx_tready;
    assign drain_exit = (state == S_DRAIN) && (!in_pkt || (beat_acc && s_tx_tlast));
    assign drain_to   = (state == S_DRAIN) && !drain_exit &&
                        (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1));
    assign hold_end   = (state == S_HOLD) && !flr_req &&
                        (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            in_pkt       <= 1'b0;
            hold_cnt     <= '0;
            drain_cnt    <= '0;
            afu_rst_n    <= 1'b0;
            flr_done     <= 1'b0;
            drain_to_err <= 1'b0;
        end else begin
            flr_done     <= 1'b0;
            drain_to_err <= 1'b0;
            afu_rst_n    <= 1'b1;
            if (beat_acc) begin
                in_pkt <= !s_tx_tlast;
            end
            unique case (state)
                S_IDLE: begin
                    if (flr_req) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_exit || drain_to) begin
                        state     <= S_HOLD;
                        hold_cnt  <= '0;
                        afu_rst_n <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                    // Timeout abandons the open packet; downstream sees it truncated.
                    if (drain_to) begin
                        drain_to_err <= 1'b1;
                        in_pkt       <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (flr_req) begin
                        hold_cnt  <= '0;
                        afu_rst_n <= 1'b0;
                    end else if (hold_end) begin
                        state    <= S_DONE;
                        flr_done <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
                        afu_rst_n <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (flr_req) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FLR_QUIESCE_STATS_EN
    // Saturating event counters, updated on the same edge that raises the matching pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_flr_cnt <= '0;
            stat_to_cnt  <= '0;
        end else begin
            if (hold_end && (stat_flr_cnt != 16'hFFFF)) begin
                stat_flr_cnt <= stat_flr_cnt + 16'd1;
            end
            if (drain_to && (stat_to_cnt != 16'hFFFF)) begin
                stat_to_cnt <= stat_to_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_afu_port_flr_quiesce.sv
// Scoreboard bench for afu_port_flr_quiesce: a time-budget reference model predicts every cycle
// and every forwarded beat; a separate monitor compares. Honours FLR_QUIESCE_STATS_EN.
module tb_afu_port_flr_quiesce;

    localparam int unsigned TDATA_W = 512;
    localparam int unsigned TUSER_W = 10;
    localparam int unsigned HOLD    = 16;
    localparam int unsigned DTO     = 4096;

    typedef struct packed {
        logic        rstn;
        logic        done;
        logic        err;
        logic        mvalid;
        logic        sready;
        logic [15:0] fc;
        logic [15:0] tc;
    } snap_t;

    typedef struct packed {
        logic               last;
        logic [TUSER_W-1:0] user;
        logic [TDATA_W-1:0] data;
    } beat_t;

    logic               clk;
    logic               rst;
    logic               flr_req;
    logic               flr_done;
    logic               afu_rst_n;
    logic               drain_to_err;
    logic               s_tx_tvalid;
    logic               s_tx_tready;
    logic               s_tx_tlast;
    logic [TDATA_W-1:0] s_tx_tdata;
    logic [TUSER_W-1:0] s_tx_tuser;
    logic               m_tx_tvalid;
    logic               m_tx_tready;
    logic               m_tx_tlast;
    logic [TDATA_W-1:0] m_tx_tdata;
    logic [TUSER_W-1:0] m_tx_tuser;
`ifdef FLR_QUIESCE_STATS_EN
    logic [15:0]        stat_flr_cnt;
    logic [15:0]        stat_to_cnt;
`endif

    afu_port_flr_quiesce #(
        .TDATA_W         (TDATA_W),
        .TUSER_W         (TUSER_W),
        .RST_HOLD_CYCLES (HOLD),
        .DRAIN_TIMEOUT   (DTO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flr_req      (flr_req),
        .flr_done     (flr_done),
        .afu_rst_n    (afu_rst_n),
        .drain_to_err (drain_to_err),
        .s_tx_tvalid  (s_tx_tvalid),
        .s_tx_tready  (s_tx_tready),
        .s_tx_tlast   (s_tx_tlast),
        .s_tx_tdata   (s_tx_tdata),
        .s_tx_tuser   (s_tx_tuser),
        .m_tx_tvalid  (m_tx_tvalid),
        .m_tx_tready  (m_tx_tready),
        .m_tx_tlast   (m_tx_tlast),
        .m_tx_tdata   (m_tx_tdata),
        .m_tx_tuser   (m_tx_tuser)
`ifdef FLR_QUIESCE_STATS_EN
        ,
        .stat_flr_cnt (stat_flr_cnt),
        .stat_to_cnt  (stat_to_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Knobs written by the sequencer only.
    bit  rst_cmd     = 1'b1;
    int  p_valid     = 0;
    int  p_ready     = 100;
    int  p_flr       = 0;
    int  fixed_len   = 0;
    int  kick_req    = 0;
    bit  finish_req  = 1'b0;

    // Written by the model only.
    bit  hs          = 1'b0;
    bit  m_pkt_open  = 1'b0;
    int  m_hold_left = 0;

    snap_t exp_q[$];
    beat_t beat_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // AFU + mux driver: AXI-stream legal source, random sink ready, FLR pulses.
    initial begin
        int kick_seen = 0;
        int pkt_len   = 1;
        int beat_no   = 0;
        rst = 1'b1; flr_req = 1'b0; s_tx_tvalid = 1'b0; m_tx_tready = 1'b0;
        s_tx_tlast = 1'b0; s_tx_tdata = '0; s_tx_tuser = '0;
        forever begin
            @(posedge clk); #1;
            rst       = rst_cmd;
            flr_req   = (kick_req != kick_seen) || ($urandom_range(0, 999) < p_flr);
            kick_seen = kick_req;
            if (hs) begin
                beat_no = s_tx_tlast ? 0 : beat_no + 1;
            end
            if (hs || !s_tx_tvalid) begin
                if (beat_no == 0) pkt_len = (fixed_len != 0) ? fixed_len : $urandom_range(1, 6);
                s_tx_tlast = (beat_no == pkt_len - 1);
                for (int i = 0; i < TDATA_W / 32; i++) s_tx_tdata[i*32 +: 32] = $urandom();
                s_tx_tuser  = TUSER_W'($urandom());
                s_tx_tvalid = ($urandom_range(0, 99) < p_valid);
            end
            m_tx_tready = ($urandom_range(0, 99) < p_ready);
        end
    end

    // Reference model: tracks remaining drain budget / reset time and predicts the next cycle.
    initial begin
        int  drain_age = -1;
        int  hold_left = 0;
        bit  in_done   = 1'b0;
        bit  err_now   = 1'b0;
        bit  rst_seen  = 1'b1;
        bit  pkt_open  = 1'b0;
        int  fc        = 0;
        int  tc        = 0;
        bit  open, acc, pkt_next, nxt_done, nxt_err;
        snap_t e;
        forever begin
            @(negedge clk);
            hs = s_tx_tvalid && s_tx_tready;
            open     = !rst && ((drain_age < 0 && hold_left == 0 && !in_done) ||
                                (drain_age >= 0 && pkt_open));
            e.rstn   = !(rst_seen || hold_left > 0);
            e.done   = in_done;
            e.err    = err_now;
            e.mvalid = s_tx_tvalid && open;
            e.sready = rst ? 1'b0 : (open ? m_tx_tready : (hold_left > 0));
`ifdef FLR_QUIESCE_STATS_EN
            e.fc = 16'(fc);
            e.tc = 16'(tc);
`else
            e.fc = '0;
            e.tc = '0;
`endif
            exp_q.push_back(e);
            acc = e.mvalid && m_tx_tready;
            if (acc) beat_q.push_back('{s_tx_tlast, s_tx_tuser, s_tx_tdata});

            if (rst) begin
                drain_age = -1; hold_left = 0; in_done = 1'b0; err_now = 1'b0;
                rst_seen = 1'b1; pkt_open = 1'b0; fc = 0; tc = 0;
            end else begin
                rst_seen = 1'b0;
                nxt_done = 1'b0;
                nxt_err  = 1'b0;
                pkt_next = acc ? !s_tx_tlast : pkt_open;
                if (in_done) begin
                    if (flr_req) drain_age = 0;
                end else if (hold_left > 0) begin
                    hold_left = flr_req ? HOLD : hold_left - 1;
                    nxt_done  = (hold_left == 0);
                end else if (drain_age >= 0) begin
                    if (!pkt_open || (acc && s_tx_tlast) || drain_age == DTO - 1) begin
                        nxt_err   = pkt_open && !(acc && s_tx_tlast);
                        drain_age = -1;
                        hold_left = HOLD;
                        pkt_open  = 1'b0;
                    end else begin
                        drain_age++;
                        pkt_open = pkt_next;
                    end
                end else begin
                    pkt_open = pkt_next;
                    if (flr_req) drain_age = 0;
                end
                in_done = nxt_done;
                err_now = nxt_err;
                if (nxt_done && fc < 65535) fc++;
                if (nxt_err && tc < 65535) tc++;
            end
            m_pkt_open  = pkt_open;
            m_hold_left = hold_left;
        end
    end

    // Monitor: pops one prediction per cycle and one beat per observed downstream transfer.
    initial begin
        snap_t e, a;
        beat_t b, ab;
        int    cyc = 0;
        while (!finish_req) begin
            @(negedge clk); #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.rstn = afu_rst_n; a.done = flr_done; a.err = drain_to_err;
                a.mvalid = m_tx_tvalid; a.sready = s_tx_tready;
`ifdef FLR_QUIESCE_STATS_EN
                a.fc = stat_flr_cnt; a.tc = stat_to_cnt;
`else
                a.fc = '0; a.tc = '0;
`endif
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs cyc=%0d got rstn/done/err/mv/sr=%b%b%b%b%b fc=%0d tc=%0d exp %b%b%b%b%b fc=%0d tc=%0d",
                             cyc, a.rstn, a.done, a.err, a.mvalid, a.sready, a.fc, a.tc,
                             e.rstn, e.done, e.err, e.mvalid, e.sready, e.fc, e.tc);
                end
            end
            if (m_tx_tvalid && m_tx_tready) begin
                ab = '{m_tx_tlast, m_tx_tuser, m_tx_tdata};
                n_tests++;
                if (beat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat cyc=%0d got last=%b user=%h none expected",
                             cyc, ab.last, ab.user);
                end else begin
                    b = beat_q.pop_front();
                    if (ab !== b) begin
                        n_fail++;
                        $display("FAIL beat_data cyc=%0d got last=%b user=%h d=%h exp last=%b user=%h d=%h",
                                 cyc, ab.last, ab.user, ab.data[63:0], b.last, b.user, b.data[63:0]);
                    end
                end
            end
        end
        n_tests++;
        if (beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_beats got %0d left over, exp 0", beat_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Sequencer.
    initial begin
        repeat (4) @(posedge clk);
        rst_cmd = 1'b0;
        repeat (5) @(posedge clk);

        // Quiet port FLR.
        kick_req++;
        repeat (30) @(posedge clk);

        // Back-to-back 4-beat packets with FLR landing at random points.
        p_valid = 100; p_ready = 100; fixed_len = 4;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(3, 9)) @(posedge clk);
            kick_req++;
            repeat (30) @(posedge clk);
        end

        // Stuck mid-packet: downstream stalls past the drain budget.
        fixed_len = 8;
        for (int i = 0; i < 200 && !m_pkt_open; i++) @(posedge clk);
        p_ready = 0;
        kick_req++;
        repeat (DTO + 100) @(posedge clk);
        p_ready = 100;
        repeat (30) @(posedge clk);

        // Re-request partway through HOLD while the AFU keeps pushing.
        kick_req++;
        for (int i = 0; i < 300 && m_hold_left == 0; i++) @(posedge clk);
        repeat (9) @(posedge clk);
        kick_req++;
        repeat (50) @(posedge clk);

        // Reset in the middle of HOLD aborts the sequence.
        kick_req++;
        for (int i = 0; i < 300 && m_hold_left == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        rst_cmd = 1'b1;
        repeat (3) @(posedge clk);
        rst_cmd = 1'b0;
        repeat (20) @(posedge clk);

        // Random soak.
        p_valid = 70; p_ready = 70; p_flr = 8; fixed_len = 0;
        repeat (3000) @(posedge clk);
        p_flr = 0; p_valid = 0;
        repeat (60) @(posedge clk);
        finish_req = 1'b1;
    end

endmodule
